// File: rtl/lab2_proc_pkg.sv
// Shared TinyRV2 encoder definitions: formats, opcodes,
// request/response bundles and the immediate range helper.
package lab2_proc_pkg;

  localparam logic [2:0] imm_i = 3'd0;
  localparam logic [2:0] imm_s = 3'd1;
  localparam logic [2:0] imm_b = 3'd2;
  localparam logic [2:0] imm_u = 3'd3;
  localparam logic [2:0] imm_j = 3'd4;
  localparam logic [2:0] enc_r = 3'd5;

  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;

  localparam logic [31:0] nop = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  ty;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_resp_t;

  // True when v[31:lsb] is all ones or all zeros.
  function automatic logic all_same(
    input logic [31:0] v,
    input int unsigned lsb
  );
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lsb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/lab2_proc_ImmPackVRTL.sv
// Combinational instruction packer: scatters the immediate
// into RISC-V bit positions and flags unencodable requests.
import lab2_proc_pkg::*;

module lab2_proc_ImmPackVRTL (
  input  logic [2:0]  ty,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic [31:0] raw;
  logic        ok;

  always_comb begin
    raw = 32'h0;
    ok  = 1'b0;
    unique case (1'b1)
      (ty == enc_r): begin
        raw = {funct7, rs2, rs1, funct3, rd, opcode};
        ok  = 1'b1;
      end
      (ty == imm_i): begin
        raw = {imm[11:0], rs1, funct3, rd, opcode};
        ok  = all_same(imm, 11);
      end
      (ty == imm_s): begin
        raw = {imm[11:5], rs2, rs1, funct3,
               imm[4:0], opcode};
        ok  = all_same(imm, 11);
      end
      (ty == imm_b): begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3,
               imm[4:1], imm[11], opcode};
        ok  = all_same(imm, 12) && !imm[0];
      end
      (ty == imm_u): begin
        raw = {imm[31:12], rd, opcode};
        ok  = (imm[11:0] == 12'h0);
      end
      (ty == imm_j): begin
        raw = {imm[20], imm[10:1], imm[11],
               imm[19:12], rd, opcode};
        ok  = all_same(imm, 20) && !imm[0];
      end
      default: begin
        raw = 32'h0;
        ok  = 1'b0;
      end
    endcase
    // Unencodable requests still answer, as a harmless nop.
    inst = ok ? raw : nop;
    err  = !ok;
  end

endmodule

// File: rtl/lab2_proc_inst_encoder.sv
// Two-stage (X, W) val/rdy TinyRV2 instruction encoder
// with a saturating count of errored responses.
import lab2_proc_pkg::*;

module lab2_proc_inst_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [2:0]  req_type,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  output logic [7:0]  err_count
);

  logic      x_val;
  enc_req_t  x_req;
  logic      w_val;
  enc_resp_t w_resp;
  enc_resp_t pk;
  logic      w_go;
  logic      x_go;
  logic      resp_fire;

  // Stall chain: a stage advances when empty or draining.
  assign w_go    = !w_val || resp_rdy;
  assign x_go    = !x_val || w_go;
  assign req_rdy = x_go;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_val <= 1'b0;
      x_req <= '0;
    end else if (x_go) begin
      x_val <= req_val;
      if (req_val) begin
        x_req <= '{ty:     req_type,
                   opcode: req_opcode,
                   funct3: req_funct3,
                   funct7: req_funct7,
                   rd:     req_rd,
                   rs1:    req_rs1,
                   rs2:    req_rs2,
                   imm:    req_imm};
      end
    end
  end

  lab2_proc_ImmPackVRTL u_pack (
    .ty     (x_req.ty),
    .opcode (x_req.opcode),
    .funct3 (x_req.funct3),
    .funct7 (x_req.funct7),
    .rd     (x_req.rd),
    .rs1    (x_req.rs1),
    .rs2    (x_req.rs2),
    .imm    (x_req.imm),
    .inst   (pk.inst),
    .err    (pk.err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_val  <= 1'b0;
      w_resp <= '0;
    end else if (w_go) begin
      w_val <= x_val;
      if (x_val) begin
        w_resp <= pk;
      end
    end
  end

  assign resp_val  = w_val;
  assign resp_inst = w_resp.inst;
  assign resp_err  = w_resp.err;
  assign resp_fire = resp_val && resp_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'h00;
    end else if (resp_fire && resp_err
                 && err_count != 8'hFF) begin
      err_count <= err_count + 8'h01;
    end
  end

endmodule

// File: doc/lab2_proc_inst_encoder.md
# lab2_proc_inst_encoder

Pipelined TinyRV2 instruction encoder: the inverse of the datapath immediate generator. It accepts decoded instruction fields (format, opcode, funct, register specifiers, full 32-bit immediate) over a val/rdy request interface. It range-checks the immediate and scatters it into the RISC-V bit positions, then returns the 32-bit instruction word over a val/rdy response interface. It is used by the self-checking instruction-memory loader and by round-trip tests of the immediate generator.

## Interface
- No parameters; all widths are fixed by TinyRV2.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_val  in  1  request valid.
- req_rdy  out  1  encoder can accept a request.
- req_type  in  3  format: 0 I, 1 S, 2 B, 3 U, 4 J (same codes as the immediate generator), 5 R, 6–7 illegal.
- req_opcode  in  7  instruction bits [6:0].
- req_funct3  in  3  instruction bits [14:12].
- req_funct7  in  7  bits [31:25]; used by R only.
- req_rd, req_rs1, req_rs2  in  5 each  register specifiers.
- req_imm  in  32  full signed immediate, byte offset for B/J.
- resp_val  out  1  response valid.
- resp_rdy  in  1  consumer ready.
- resp_inst  out  32  encoded instruction.
- resp_err  out  1  request could not be encoded.
- err_count  out  8  saturating count of errored responses delivered.

## Operation
- Two pipeline stages:
  - X: request register.
  - W: response register, holding the packed word plus the error flag.
- Packing is computed combinationally from X and captured into W.
- Packing per format:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode. Shift-immediates carry funct7 in imm[11:5].
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Legality rules:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, always legal.
  - Types 6–7: always illegal.
- Fields not used by a format are ignored.
- Illegal request: resp_err=1 and resp_inst=32'h0000_0013 (nop). A response is still produced; no request is ever dropped.
- err_count increments when an errored response handshakes (resp_val & resp_rdy & resp_err). It saturates at 8'hFF.

## Timing
- Reset (asynchronous, reset_n=0):
  - X and W valid bits clear; X/W payload registers are don't-care.
  - Outputs: resp_val=0, resp_err=0, resp_inst=0, err_count=0, req_rdy=1 (combinational from empty pipeline).
  - Assertion mid-operation discards all in-flight requests. The first response after deassertion belongs to the first request accepted after it.
- A request transfers on a rising edge with req_val & req_rdy. A response transfers on a rising edge with resp_val & resp_rdy.
- Latency: a request accepted at edge k reaches X at k. It is captured in W at edge k+1, so resp_val is high in the cycle after k+1. Minimum two edges from request handshake to response visible.
- Throughput: one per cycle while resp_rdy=1.
- Stall chain (combinational, no bubbles):
  - w_go = !w_val | resp_rdy.
  - x_go = !x_val | w_go.
  - req_rdy = x_go.
- Full pipeline with resp_rdy=0: req_rdy=0. Holding stages keep their payload stable, and resp_inst/resp_err must not change while resp_val=1 & resp_rdy=0.
- Simultaneous accept and emit in one cycle is legal at both stages.
- req_rdy depends on resp_rdy combinationally. No path from req_val to req_rdy.

## Structure
- The shared lab2_proc package holds:
  - format localparams imm_i/imm_s/imm_b/imm_u/imm_j (0–4), plus enc_r=5;
  - opcode constants;
  - the nop constant 32'h0000_0013.
- One natural sub-module, lab2_proc_ImmPackVRTL: combinational (type, fields, imm) -> (inst, err). It is instantiated between X and W and is unit-testable standalone.
- Stage valid/payload registers use the codebase's resettable register primitives.

## Test plan
- I, addi x1,x2,-1: opcode 0x13, funct3 0, rd 1, rs1 2, imm 0xFFFFFFFF -> resp_inst 0xFFF10093, err 0, two edges after accept.
- B, beq x1,x2,+8: opcode 0x63, rs1 1, rs2 2, imm 8 -> 0x00208463. J, jal x1,-4 -> 0xFFDFF0EF. U, lui x5 with imm 0x12345000 -> 0x123452B7.
- Errors:
  - I-type imm 0x800 -> err=1, inst 0x00000013, err_count 0->1.
  - B-type imm 7 -> err=1.
  - type 7 -> err=1.
  - 300 errored responses -> err_count=0xFF.
- Backpressure:
  - resp_rdy=0 with back-to-back requests -> req_rdy drops after two are held, and resp_inst stays stable.
  - release resp_rdy -> all responses arrive in order, one per cycle, none lost or duplicated.
- Reset mid-operation: pulse reset_n low asynchronously (not edge-aligned) with both stages full -> resp_val falls immediately, err_count=0. The next accepted request produces the first response.
- Round trip: for random legal imm per format, feed resp_inst into the immediate generator -> recovered imm equals req_imm.
